// File: rtl/stylize_pkg.sv
// Shared types and helpers for the stylize compositor: display modes,
// the 24-bit RGB pixel record, SDRAM word unpacking and 10-bit left-justify.
package stylize_pkg;

  typedef enum logic [1:0] {
    MODE_ORIG    = 2'd0,
    MODE_POSTER  = 2'd1,
    MODE_EDGE    = 2'd2,
    MODE_OUTLINE = 2'd3
  } mode_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  // The capture path scatters green across both SDRAM words.
  function automatic rgb24_t unpack_rgb(input logic [15:0] d1, input logic [15:0] d2);
    rgb24_t p;
    p.r = d2[9:2];
    p.g = {d1[14:10], d2[14:12]};
    p.b = d1[9:2];
    return p;
  endfunction

  // v holds a right-aligned w-bit value; move it to the top of a 10-bit DAC word.
  function automatic logic [9:0] left_justify10(input logic [9:0] v, input int unsigned w);
    return v << (10 - w);
  endfunction

endpackage

// File: rtl/stylize_fifo.sv
// Alignment FIFO holding pixel colour until the matching edge result returns.
// Push and pop may coincide even when full; clear has priority over both.
module stylize_fifo
  import stylize_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic                   i_push,
  input  rgb24_t                 i_wdata,
  input  logic                   i_pop,
  output rgb24_t                 o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_fill,
  output logic [$clog2(DEPTH):0] o_fill_next
);

  localparam int AW = $clog2(DEPTH);

  rgb24_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign o_full  = (o_fill == (AW+1)'(DEPTH));
  assign o_empty = (o_fill == '0);
  assign do_pop  = i_pop && !i_clear && !o_empty;
  assign do_push = i_push && !i_clear && (!o_full || do_pop);
  assign o_rdata = mem[rd_ptr];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    o_fill_next = o_fill;
    if (i_clear) o_fill_next = '0;
    else         o_fill_next = o_fill + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_fill <= '0;
    end else begin
      o_fill <= o_fill_next;
      if (i_clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; fill/empty gate every read, so its contents never leak.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/stylize_compositor.sv
// Oil-painting output stage: unpacks SDRAM pixels, feeds gray to the edge engine,
// and composites the delayed colour with the returned edge magnitude.
module stylize_compositor
  import stylize_pkg::*;
#(
  parameter int COLOR_BITS   = 3,
  parameter int GRAY_W       = 4,
  parameter int EDGE_W       = 4,
  parameter int DEPTH        = 16,
  parameter int PAUSE_MARGIN = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic [1:0]             i_mode,
  input  logic [EDGE_W-1:0]      i_threshold,
  input  logic                   i_pix_valid,
  input  logic [15:0]            i_sdram_data_1,
  input  logic [15:0]            i_sdram_data_2,
  output logic [GRAY_W-1:0]      o_gray,
  output logic                   o_gray_valid,
  input  logic                   i_edge_valid,
  input  logic [EDGE_W-1:0]      i_edge,
  output logic [9:0]             o_red,
  output logic [9:0]             o_green,
  output logic [9:0]             o_blue,
  output logic                   o_valid,
  output logic                   o_pause,
  output logic [$clog2(DEPTH):0] o_fill,
  output logic                   o_overflow,
  output logic                   o_underflow
);

  localparam int FILL_W = $clog2(DEPTH) + 1;
  localparam logic [FILL_W-1:0] PAUSE_LEVEL = FILL_W'(DEPTH - PAUSE_MARGIN);

  rgb24_t            pix_in;
  rgb24_t            pix_q;
  rgb24_t            head;
  logic [9:0]        gray_sum;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FILL_W-1:0] fill_next;
  logic [29:0]       composite;
  mode_t             mode;
  logic              unused_ok;

  function automatic logic [9:0] posterize(input logic [7:0] ch);
    return left_justify10(10'(ch >> (8 - COLOR_BITS)), COLOR_BITS);
  endfunction

  assign pix_in    = unpack_rgb(i_sdram_data_1, i_sdram_data_2);
  assign gray_sum  = 10'(pix_in.r) + {1'b0, pix_in.g, 1'b0} + 10'(pix_in.b);
  assign mode      = mode_t'(i_mode);
  assign unused_ok = ^{gray_sum, i_sdram_data_1, i_sdram_data_2};

  // Stage 1: o_gray_valid doubles as the FIFO push strobe for the latched pixel.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (i_rst) begin
      pix_q        <= '0;
      o_gray       <= '0;
      o_gray_valid <= 1'b0;
    end else begin
      o_gray_valid <= i_pix_valid;
      if (i_pix_valid) begin
        pix_q  <= pix_in;
        o_gray <= gray_sum[9 -: GRAY_W];
      end
    end
  end

  stylize_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (i_clear),
    .i_push      (o_gray_valid),
    .i_wdata     (pix_q),
    .i_pop       (i_edge_valid),
    .o_rdata     (head),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_fill      (o_fill),
    .o_fill_next (fill_next)
  );

  always_comb begin
    composite = '0;
    case (mode)
      MODE_ORIG:    composite = {head.r, 2'b00, head.g, 2'b00, head.b, 2'b00};
      MODE_POSTER:  composite = {posterize(head.r), posterize(head.g), posterize(head.b)};
      MODE_EDGE:    composite = {3{left_justify10(10'(i_edge), EDGE_W)}};
      MODE_OUTLINE: if (i_edge < i_threshold)
                      composite = {posterize(head.r), posterize(head.g), posterize(head.b)};
      default:      composite = '0;
    endcase
  end

  // Pop-on-empty still answers the edge engine, with black.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_red       <= '0;
      o_green     <= '0;
      o_blue      <= '0;
      o_valid     <= 1'b0;
      o_pause     <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (i_clear) begin
      o_red       <= '0;
      o_green     <= '0;
      o_blue      <= '0;
      o_valid     <= 1'b0;
      o_pause     <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_valid <= i_edge_valid;
      o_pause <= (fill_next >= PAUSE_LEVEL);
      if (i_edge_valid) begin
        {o_red, o_green, o_blue} <= fifo_empty ? 30'd0 : composite;
        if (fifo_empty) o_underflow <= 1'b1;
      end
      if (o_gray_valid && fifo_full && !i_edge_valid) o_overflow <= 1'b1;
    end
  end

endmodule
